conv_pingpong_buf: RTL and testbench

Double-banked feature-map buffer for the CNN datapath. A single-port producer, such as the previous layer's output stage, fills one bank while the convolution engine reads up to PORT_NUM window taps per cycle from the other bank. Banks swap through explicit fill-complete and release handshakes, so a layer's output and the next layer's input overlap without corrupting each other.

---
 rtl/conv_buf_pkg.sv | 19 +
 rtl/conv_buf_bank.sv | 32 +++
 rtl/conv_pingpong_buf.sv | 123 ++++++++++++
 tb/tb_conv_pingpong_buf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_buf_pkg.sv
// rtl/conv_buf_pkg.sv - shared types and index helpers for the ping-pong conv buffer
package conv_buf_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_e;

    // Bank index width; a one-word bank still needs a 1-bit index.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // LSB of field `port` in a packed bus of `width`-bit fields.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/conv_buf_bank.sv
// rtl/conv_buf_bank.sv - one DEPTH x WIDTH bank, 1 write port, PORT_NUM async read ports
module conv_buf_bank
    import conv_buf_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int WIDTH    = 16,
    parameter int PORT_NUM = 25,
    parameter int IDX_W    = idx_width(DEPTH)
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [IDX_W-1:0]          waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [PORT_NUM*IDX_W-1:0] raddr,
    output logic [PORT_NUM*WIDTH-1:0] rdata
);

    // Contents are deliberately not reset so the array can map to block RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port commits on the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
        assign rdata[port_lsb(p, WIDTH) +: WIDTH] = mem[raddr[port_lsb(p, IDX_W) +: IDX_W]];
    end

endmodule

// File: rtl/conv_pingpong_buf.sv
// rtl/conv_pingpong_buf.sv - double-banked feature-map buffer; CONV_BUF_ZERO_PAD_EN zero-fills out-of-range read taps
module conv_pingpong_buf
    import conv_buf_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int PORT_NUM   = 25
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           wr_last,
    input  logic                           rd_req,
    input  logic [PORT_NUM*ADDR_WIDTH-1:0] rd_addr,
    output logic [PORT_NUM*WIDTH-1:0]      rd_data,
    output logic                           rd_valid,
    input  logic                           rd_done,
    output logic                           bank_avail,
    output logic                           wr_bank,
    output logic                           rd_bank
);

    localparam int IDX_W = idx_width(DEPTH);

    bank_state_e state [2];
    bank_state_e state_next [2];
    logic        wsel, wsel_next;
    logic        rsel, rsel_next;

    logic        wr_fire, rd_fire, release_fire, wr_in_range;
    logic [PORT_NUM*IDX_W-1:0] rd_idx;
    logic [PORT_NUM*WIDTH-1:0] bank_rdata [2];
    logic [PORT_NUM*WIDTH-1:0] rd_mux;

    // Handshake flags come only from registered state, never from same-cycle requests.
    assign wr_ready     = (state[wsel] == EMPTY);
    assign bank_avail   = (state[rsel] == FULL);
    assign wr_fire      = wr_valid & wr_ready;
    assign rd_fire      = rd_req & bank_avail;
    assign release_fire = rd_done & bank_avail;
    assign wr_in_range  = (wr_addr[ADDR_WIDTH-1:IDX_W] == '0);
    assign wr_bank      = wsel;
    assign rd_bank      = rsel;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        conv_buf_bank #(
            .DEPTH    (DEPTH),
            .WIDTH    (WIDTH),
            .PORT_NUM (PORT_NUM),
            .IDX_W    (IDX_W)
        ) u_bank (
            .clk   (clk),
            .we    (wr_fire && wr_in_range && (wsel == 1'(b))),
            .waddr (wr_addr[IDX_W-1:0]),
            .wdata (wr_data),
            .raddr (rd_idx),
            .rdata (bank_rdata[b])
        );
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_rport
        localparam int ALSB = port_lsb(p, ADDR_WIDTH);
        localparam int DLSB = port_lsb(p, WIDTH);
        assign rd_idx[port_lsb(p, IDX_W) +: IDX_W] = rd_addr[ALSB +: IDX_W];
`ifdef CONV_BUF_ZERO_PAD_EN
        // Taps outside the feature map read as zero padding.
        assign rd_mux[DLSB +: WIDTH] = (rd_addr[ALSB+IDX_W +: ADDR_WIDTH-IDX_W] == '0)
                                     ? bank_rdata[rsel][DLSB +: WIDTH] : '0;
`else
        // High address bits are ignored: the tap wraps modulo DEPTH.
        logic unused_hi;
        assign unused_hi = ^rd_addr[ALSB+IDX_W +: ADDR_WIDTH-IDX_W];
        assign rd_mux[DLSB +: WIDTH] = bank_rdata[rsel][DLSB +: WIDTH];
`endif
    end

    // Bank ownership: wr_last fills the write bank, rd_done frees the read bank; never the same bank.
    always_comb begin
        state_next = state;
        wsel_next  = wsel;
        rsel_next  = rsel;
        if (wr_fire && wr_last) begin
            state_next[wsel] = FULL;
            wsel_next        = ~wsel;
        end
        if (release_fire) begin
            state_next[rsel] = EMPTY;
            rsel_next        = ~rsel;
        end
    end

    // Bank state and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
            wsel     <= 1'b0;
            rsel     <= 1'b0;
        end else begin
            state <= state_next;
            wsel  <= wsel_next;
            rsel  <= rsel_next;
        end
    end

    // Read result register; holds its value when a request is not accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_conv_pingpong_buf.sv
// tb/tb_conv_pingpong_buf.sv - randomized self-checking bench for conv_pingpong_buf
module tb_conv_pingpong_buf;

    localparam int D  = 1024;
    localparam int W  = 16;
    localparam int AW = 32;
    localparam int P  = 25;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [AW-1:0]   wr_addr = '0;
    logic [W-1:0]    wr_data = '0;
    logic            wr_last = 1'b0;
    logic            rd_req = 1'b0;
    logic [P*AW-1:0] rd_addr = '0;
    logic [P*W-1:0]  rd_data;
    logic            rd_valid;
    logic            rd_done = 1'b0;
    logic            bank_avail;
    logic            wr_bank;
    logic            rd_bank;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: bank contents, full flags, pointers and the last accepted read.
    logic [W-1:0] mmem [2][D];
    bit           mfull [2];
    bit           mwsel, mrsel;
    logic [W-1:0] mrd [P];
    bit           mrd_valid;

    always #5 clk = ~clk;

    conv_pingpong_buf #(.DEPTH(D), .WIDTH(W), .ADDR_WIDTH(AW), .PORT_NUM(P)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_last(wr_last),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_done(rd_done), .bank_avail(bank_avail), .wr_bank(wr_bank), .rd_bank(rd_bank)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mread(input bit b, input logic [AW-1:0] a);
`ifdef CONV_BUF_ZERO_PAD_EN
        if (a >= D) return '0;
        return mmem[b][a[9:0]];
`else
        return mmem[b][int'(a % D)];
`endif
    endfunction

    task automatic model_reset();
        mfull[0] = 0; mfull[1] = 0; mwsel = 0; mrsel = 0; mrd_valid = 0;
        for (int i = 0; i < P; i++) mrd[i] = '0;
    endtask

    // One clock: the model applies the inputs seen at the edge, then outputs settle.
    task automatic cycle();
        bit avail, ready;
        @(posedge clk);
        avail = mfull[mrsel];
        ready = !mfull[mwsel];
        if (rd_req && avail) begin
            for (int i = 0; i < P; i++) mrd[i] = mread(mrsel, rd_addr[i*AW +: AW]);
            mrd_valid = 1;
        end else begin
            mrd_valid = 0;
        end
        if (wr_valid && ready) begin
            if (wr_addr < D) mmem[mwsel][wr_addr[9:0]] = wr_data;
            if (wr_last) begin mfull[mwsel] = 1; mwsel = !mwsel; end
        end
        if (rd_done && avail) begin mfull[mrsel] = 0; mrsel = !mrsel; end
        #1;
    endtask

    task automatic fill(input bit addr_as_data, input bit gaps);
        for (int a = 0; a < D; a++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wr_valid = 0;
                cycle();
            end
            wr_valid = 1;
            wr_addr  = AW'(a);
            wr_data  = addr_as_data ? W'(a) : W'($urandom);
            wr_last  = (a == D - 1);
            cycle();
        end
        wr_valid = 0;
        wr_last  = 0;
    endtask

    task automatic rand_addrs(input int maxa);
        for (int i = 0; i < P; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, maxa));
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b want 1", wr_ready); else pass_cnt++;
        total_cnt++; if (bank_avail !== 1'b0) $display("FAIL reset_bank_avail: got %b want 0", bank_avail); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else pass_cnt++;
        total_cnt++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else pass_cnt++;
        total_cnt++; if (wr_bank !== 1'b0) $display("FAIL reset_wr_bank: got %b want 0", wr_bank); else pass_cnt++;
        total_cnt++; if (rd_bank !== 1'b0) $display("FAIL reset_rd_bank: got %b want 0", rd_bank); else pass_cnt++;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cycle();
    endtask

    task automatic test_fill_read_b0();
        fill(1'b1, 1'b0);
        total_cnt++; if (bank_avail !== 1'b1) $display("FAIL fill0_bank_avail: got %b want 1", bank_avail); else pass_cnt++;
        total_cnt++; if (wr_bank !== 1'b1) $display("FAIL fill0_wr_bank: got %b want 1", wr_bank); else pass_cnt++;
        total_cnt++; if (wr_ready !== 1'b1) $display("FAIL fill0_wr_ready: got %b want 1", wr_ready); else pass_cnt++;
        for (int i = 0; i < P; i++) rd_addr[i*AW +: AW] = AW'(41 * i);
        rd_req = 1;
        cycle();
        rd_req = 0;
        total_cnt++; if (rd_valid !== 1'b1) $display("FAIL read41_valid: got %b want 1", rd_valid); else pass_cnt++;
        for (int i = 0; i < P; i++) begin
            total_cnt++;
            if (rd_data[i*W +: W] !== W'(41 * i))
                $display("FAIL read41_port%0d: got %0d want %0d", i, rd_data[i*W +: W], 41 * i);
            else pass_cnt++;
        end
    endtask

    task automatic test_both_full();
        fill(1'b0, 1'b1);
        total_cnt++; if (wr_ready !== 1'b0) $display("FAIL both_full_wr_ready: got %b want 0", wr_ready); else pass_cnt++;
        total_cnt++; if (bank_avail !== 1'b1) $display("FAIL both_full_bank_avail: got %b want 1", bank_avail); else pass_cnt++;
        rd_done = 1;
        cycle();
        rd_done = 0;
        total_cnt++; if (rd_bank !== 1'b1) $display("FAIL release0_rd_bank: got %b want 1", rd_bank); else pass_cnt++;
        total_cnt++; if (wr_ready !== 1'b1) $display("FAIL release0_wr_ready: got %b want 1", wr_ready); else pass_cnt++;
        total_cnt++; if (wr_bank !== 1'b0) $display("FAIL release0_wr_bank: got %b want 0", wr_bank); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) begin
            rand_addrs(D - 1);
            rd_req = ($urandom_range(0, 3) != 0);
            cycle();
            total_cnt++;
            if (rd_valid !== mrd_valid) $display("FAIL b2b_valid[%0d]: got %b want %b", k, rd_valid, mrd_valid);
            else pass_cnt++;
            for (int i = 0; i < P; i++) begin
                total_cnt++;
                if (rd_data[i*W +: W] !== mrd[i])
                    $display("FAIL b2b_data[%0d] port%0d: got %h want %h", k, i, rd_data[i*W +: W], mrd[i]);
                else pass_cnt++;
            end
        end
        rd_req = 0;
    endtask

    task automatic test_read_release();
        rand_addrs(D - 1);
        rd_req  = 1;
        rd_done = 1;
        cycle();
        rd_done = 0;
        total_cnt++; if (rd_valid !== 1'b1) $display("FAIL rr_valid: got %b want 1", rd_valid); else pass_cnt++;
        for (int i = 0; i < P; i++) begin
            total_cnt++;
            if (rd_data[i*W +: W] !== mrd[i])
                $display("FAIL rr_data port%0d: got %h want %h", i, rd_data[i*W +: W], mrd[i]);
            else pass_cnt++;
        end
        total_cnt++; if (rd_bank !== 1'b0) $display("FAIL rr_rd_bank: got %b want 0", rd_bank); else pass_cnt++;
        rand_addrs(D - 1);
        cycle();
        rd_req = 0;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL empty_rd_valid: got %b want 0", rd_valid); else pass_cnt++;
        for (int i = 0; i < P; i++) begin
            total_cnt++;
            if (rd_data[i*W +: W] !== mrd[i])
                $display("FAIL empty_hold port%0d: got %h want %h", i, rd_data[i*W +: W], mrd[i]);
            else pass_cnt++;
        end
        rd_done = 1;
        cycle();
        rd_done = 0;
        total_cnt++; if (rd_bank !== 1'b0) $display("FAIL ignored_done_rd_bank: got %b want 0", rd_bank); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        logic [W-1:0] exp3;
        fill(1'b1, 1'b1);
        wr_valid = 1; wr_addr = AW'(2000); wr_data = W'($urandom); wr_last = 1;
        cycle();
        wr_valid = 0; wr_last = 0;
        total_cnt++; if (wr_ready !== 1'b0) $display("FAIL oob_wr_full: got %b want 0", wr_ready); else pass_cnt++;
        total_cnt++; if (wr_bank !== 1'b0) $display("FAIL oob_wr_bank: got %b want 0", wr_bank); else pass_cnt++;
        rand_addrs(2 * D - 1);
        rd_addr[3*AW +: AW] = AW'(1029);
        rd_req = 1;
        cycle();
        rd_req = 0;
`ifdef CONV_BUF_ZERO_PAD_EN
        exp3 = '0;
`else
        exp3 = W'(5);
`endif
        total_cnt++; if (rd_data[3*W +: W] !== exp3) $display("FAIL oob_port3: got %0d want %0d", rd_data[3*W +: W], exp3); else pass_cnt++;
        for (int i = 0; i < P; i++) begin
            total_cnt++;
            if (rd_data[i*W +: W] !== mrd[i])
                $display("FAIL oob_rd port%0d: got %h want %h", i, rd_data[i*W +: W], mrd[i]);
            else pass_cnt++;
        end
        rd_done = 1;
        cycle();
        rd_done = 0;
        rand_addrs(D - 1);
        rd_addr[0 +: AW]  = AW'(976);
        rd_addr[AW +: AW] = AW'(2000);
        rd_req = 1;
        cycle();
        total_cnt++; if (rd_valid !== 1'b1) $display("FAIL oob_b1_valid: got %b want 1", rd_valid); else pass_cnt++;
        for (int i = 0; i < P; i++) begin
            total_cnt++;
            if (rd_data[i*W +: W] !== mrd[i])
                $display("FAIL oob_b1 port%0d: got %h want %h", i, rd_data[i*W +: W], mrd[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_read();
        for (int k = 0; k < 3; k++) begin
            rand_addrs(D - 1);
            cycle();
        end
        total_cnt++; if (rd_valid !== 1'b1) $display("FAIL midrst_pre_valid: got %b want 1", rd_valid); else pass_cnt++;
        #2;
        rst_n = 0;
        #1;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL midrst_rd_valid: got %b want 0", rd_valid); else pass_cnt++;
        total_cnt++; if (rd_data !== '0) $display("FAIL midrst_rd_data: got %h want 0", rd_data); else pass_cnt++;
        total_cnt++; if (bank_avail !== 1'b0) $display("FAIL midrst_bank_avail: got %b want 0", bank_avail); else pass_cnt++;
        total_cnt++; if (wr_ready !== 1'b1) $display("FAIL midrst_wr_ready: got %b want 1", wr_ready); else pass_cnt++;
        total_cnt++; if (rd_bank !== 1'b0) $display("FAIL midrst_rd_bank: got %b want 0", rd_bank); else pass_cnt++;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cycle();
        rd_req = 0;
        total_cnt++; if (rd_valid !== mrd_valid) $display("FAIL postrst_rd_valid: got %b want %b", rd_valid, mrd_valid); else pass_cnt++;
        total_cnt++; if (bank_avail !== 1'b0) $display("FAIL postrst_bank_avail: got %b want 0", bank_avail); else pass_cnt++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_read_b0();
        test_both_full();
        test_back_to_back();
        test_read_release();
        test_out_of_range();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
